// File: rtl/core_pkg.sv
// core_pkg: shared memory-stage types for the LEGv8 pipeline.
package core_pkg;
   typedef enum logic {IDLE, WAIT} mem_state_t;
   typedef struct packed {
      logic       valid;
      logic       MemRead;
      logic       MemWrite;
      logic       Branch;
      logic       RegWrite;
      logic       MemtoReg;
      logic [4:0] WriteReg;
   } ex_mem_ctrl_t;
   typedef struct packed {
      logic       valid;
      logic       RegWrite;
      logic       MemtoReg;
      logic [4:0] WriteReg;
   } mem_wb_ctrl_t;
endpackage

// File: rtl/dmem_handshake.sv
// dmem_handshake: valid/ack sequencer with wait counter and timeout abort.
module dmem_handshake
   import core_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic i_memop,
   input  logic i_ack,
   output logic o_req,
   output logic o_stall,
   output logic o_done,
   output logic o_abort,
   output logic o_err
);
   localparam int CW = $clog2(TIMEOUT);
   mem_state_t    r_state, w_state_nx;
   logic [CW-1:0] r_cnt, w_cnt_nx;
   logic          r_err;
   always_comb begin
      o_req      = i_memop;
      o_abort    = (r_state == WAIT) & ~i_ack & (r_cnt == CW'(TIMEOUT - 1));
      o_done     = o_req & (i_ack | o_abort);
      o_stall    = o_req & ~i_ack & ~o_abort;
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      if (r_state == IDLE) begin
         if (o_stall) begin
            w_state_nx = WAIT;
            w_cnt_nx   = CW'(1);
         end
      end else if (i_ack | o_abort) begin
         w_state_nx = IDLE;
         w_cnt_nx   = '0;
      end else begin
         w_cnt_nx   = r_cnt + CW'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_err   <= r_err | o_abort;
      end
   end
   assign o_err = r_err;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, data-memory handshake, branch resolve and MEM/WB register.
module mem_stage
   import core_pkg::*;
#(
   parameter int N       = 64,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_E,
   input  logic         MemRead_E,
   input  logic         MemWrite_E,
   input  logic         Branch_E,
   input  logic         RegWrite_E,
   input  logic         MemtoReg_E,
   input  logic [4:0]   WriteReg_E,
   input  logic [N-1:0] PCBranch_E,
   input  logic [N-1:0] aluResult_E,
   input  logic [N-1:0] writeData_E,
   input  logic         zero_E,
   input  logic         dmem_ack,
   input  logic [N-1:0] dmem_rdata,
   output logic         dmem_req,
   output logic         dmem_we,
   output logic [N-1:0] dmem_addr,
   output logic [N-1:0] dmem_wdata,
   output logic         stall,
   output logic         PCSrc_M,
   output logic [N-1:0] PCBranch_M,
   output logic         valid_W,
   output logic         RegWrite_W,
   output logic         MemtoReg_W,
   output logic [4:0]   WriteReg_W,
   output logic [N-1:0] aluResult_W,
   output logic [N-1:0] readData_W,
   output logic         mem_err
);
   ex_mem_ctrl_t r_ctrl_M;
   mem_wb_ctrl_t r_ctrl_W;
   logic [N-1:0] r_pcb_M, r_alu_M, r_wd_M, r_alu_W, r_rd_W;
   logic         r_zero_M;
   logic         w_memop, w_done, w_abort;
   assign w_memop = r_ctrl_M.valid & (r_ctrl_M.MemRead | r_ctrl_M.MemWrite);
   dmem_handshake #(.TIMEOUT(TIMEOUT)) u_hs (
      .clk     (clk),
      .reset   (reset),
      .i_memop (w_memop),
      .i_ack   (dmem_ack),
      .o_req   (dmem_req),
      .o_stall (stall),
      .o_done  (w_done),
      .o_abort (w_abort),
      .o_err   (mem_err)
   );
   assign PCSrc_M = r_ctrl_M.valid & r_ctrl_M.Branch & r_zero_M;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctrl_M <= '0;
         r_pcb_M  <= '0;
         r_alu_M  <= '0;
         r_wd_M   <= '0;
         r_zero_M <= 1'b0;
      end else if (!stall) begin
         r_ctrl_M <= '{valid_E & ~PCSrc_M, MemRead_E, MemWrite_E, Branch_E,
                       RegWrite_E, MemtoReg_E, WriteReg_E};
         r_pcb_M  <= PCBranch_E;
         r_alu_M  <= aluResult_E;
         r_wd_M   <= writeData_E;
         r_zero_M <= zero_E;
      end
   end
   // Only a read that is actually acked carries memory data into writeback.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctrl_W <= '0;
         r_alu_W  <= '0;
         r_rd_W   <= '0;
      end else begin
         r_ctrl_W <= '{r_ctrl_M.valid & ~stall & ~w_abort, r_ctrl_M.RegWrite,
                       r_ctrl_M.MemtoReg, r_ctrl_M.WriteReg};
         r_alu_W  <= r_alu_M;
         r_rd_W   <= (w_done & dmem_ack & r_ctrl_M.MemRead) ? dmem_rdata : '0;
      end
   end
   assign dmem_we     = r_ctrl_M.MemWrite;
   assign dmem_addr   = r_alu_M;
   assign dmem_wdata  = r_wd_M;
   assign PCBranch_M  = r_pcb_M;
   assign valid_W     = r_ctrl_W.valid;
   assign RegWrite_W  = r_ctrl_W.RegWrite;
   assign MemtoReg_W  = r_ctrl_W.MemtoReg;
   assign WriteReg_W  = r_ctrl_W.WriteReg;
   assign aluResult_W = r_alu_W;
   assign readData_W  = r_rd_W;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of the LEGv8 memory stage.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid_E, MemRead_E, MemWrite_E, Branch_E, RegWrite_E, MemtoReg_E, zero_E;
   logic [4:0]  WriteReg_E;
   logic [63:0] PCBranch_E, aluResult_E, writeData_E;
   logic        dmem_ack;
   logic [63:0] dmem_rdata;
   logic        dmem_req, dmem_we, stall, PCSrc_M, valid_W, RegWrite_W, MemtoReg_W, mem_err;
   logic [63:0] dmem_addr, dmem_wdata, PCBranch_M, aluResult_W, readData_W;
   logic [4:0]  WriteReg_W;
   int          n_vec = 0;
   int          n_err = 0;
   mem_stage dut (
      .clk(clk), .reset(reset), .valid_E(valid_E), .MemRead_E(MemRead_E),
      .MemWrite_E(MemWrite_E), .Branch_E(Branch_E), .RegWrite_E(RegWrite_E),
      .MemtoReg_E(MemtoReg_E), .WriteReg_E(WriteReg_E), .PCBranch_E(PCBranch_E),
      .aluResult_E(aluResult_E), .writeData_E(writeData_E), .zero_E(zero_E),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .stall(stall), .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M), .valid_W(valid_W),
      .RegWrite_W(RegWrite_W), .MemtoReg_W(MemtoReg_W), .WriteReg_W(WriteReg_W),
      .aluResult_W(aluResult_W), .readData_W(readData_W), .mem_err(mem_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic set_e(input logic v, rd, wr, br, rw, m2r, input logic [4:0] wreg,
                        input logic [63:0] pcb, alu, wd, input logic z);
      valid_E = v; MemRead_E = rd; MemWrite_E = wr; Branch_E = br; RegWrite_E = rw;
      MemtoReg_E = m2r; WriteReg_E = wreg; PCBranch_E = pcb; aluResult_E = alu;
      writeData_E = wd; zero_E = z;
   endtask
   initial begin
      set_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      dmem_ack = 0; dmem_rdata = 0;
      tick(); tick();
      reset = 0;
      #1;
      chk("rst_req", dmem_req, 0);
      chk("rst_stall", stall, 0);
      chk("rst_pcsrc", PCSrc_M, 0);
      chk("rst_valid_w", valid_W, 0);
      chk("rst_err", mem_err, 0);
      chk("rst_alu_w", aluResult_W, 0);
      // plain ALU op
      set_e(1, 0, 0, 0, 1, 0, 5, 0, 64'h2A, 0, 0);
      tick(); set_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("alu_stall", stall, 0);
      chk("alu_req", dmem_req, 0);
      tick();
      chk("alu_valid_w", valid_W, 1);
      chk("alu_wreg_w", WriteReg_W, 5);
      chk("alu_res_w", aluResult_W, 64'h2A);
      chk("alu_rw_w", RegWrite_W, 1);
      // load with same-cycle ack
      set_e(1, 1, 0, 0, 1, 1, 3, 0, 64'h100, 0, 0);
      tick(); set_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      dmem_ack = 1; dmem_rdata = 64'hDEAD; #1;
      chk("ld_req", dmem_req, 1);
      chk("ld_addr", dmem_addr, 64'h100);
      chk("ld_we", dmem_we, 0);
      chk("ld_stall", stall, 0);
      tick(); dmem_ack = 0; dmem_rdata = 0; #1;
      chk("ld_valid_w", valid_W, 1);
      chk("ld_rdata_w", readData_W, 64'hDEAD);
      chk("ld_m2r_w", MemtoReg_W, 1);
      chk("ld_req_off", dmem_req, 0);
      // store acked after 3 wait cycles, ALU op queued behind it
      set_e(1, 0, 1, 0, 0, 0, 0, 0, 64'h80, 64'h55, 0);
      tick(); set_e(1, 0, 0, 0, 1, 0, 7, 0, 64'h77, 0, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("st_req", dmem_req, 1);
         chk("st_we", dmem_we, 1);
         chk("st_addr", dmem_addr, 64'h80);
         chk("st_wdata", dmem_wdata, 64'h55);
         chk("st_stall", stall, 1);
         if (i > 0) chk("st_valid_w_wait", valid_W, 0);
         tick();
      end
      dmem_ack = 1; #1;
      chk("st_req_ack", dmem_req, 1);
      chk("st_wdata_ack", dmem_wdata, 64'h55);
      chk("st_stall_ack", stall, 0);
      tick(); dmem_ack = 0; set_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("st_valid_w", valid_W, 1);
      chk("st_next_req", dmem_req, 0);
      tick();
      chk("st_next_valid_w", valid_W, 1);
      chk("st_next_wreg", WriteReg_W, 7);
      chk("st_next_alu", aluResult_W, 64'h77);
      // taken CBZ squashes the following instruction
      set_e(1, 0, 0, 1, 0, 0, 0, 64'h400, 0, 0, 1);
      tick(); set_e(1, 0, 0, 0, 1, 0, 9, 0, 64'h99, 0, 0); #1;
      chk("br_pcsrc", PCSrc_M, 1);
      chk("br_target", PCBranch_M, 64'h400);
      tick(); set_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("br_pcsrc_off", PCSrc_M, 0);
      tick();
      chk("br_squash_w", valid_W, 0);
      // load never acked: timeout abort
      set_e(1, 1, 0, 0, 1, 1, 4, 0, 64'h200, 0, 0);
      tick(); set_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 15; i++) begin
         #1;
         chk("to_stall", stall, 1);
         tick();
      end
      #1;
      chk("to_stall_drop", stall, 0);
      chk("to_req_last", dmem_req, 1);
      chk("to_err_before", mem_err, 0);
      tick();
      chk("to_valid_w", valid_W, 0);
      chk("to_err", mem_err, 1);
      chk("to_req_off", dmem_req, 0);
      tick(); tick();
      chk("to_err_sticky", mem_err, 1);
      // reset during the wait of a delayed load
      set_e(1, 1, 0, 0, 1, 1, 6, 0, 64'h300, 0, 0);
      tick(); set_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick(); #1;
      chk("rw_stall_pre", stall, 1);
      reset = 1;
      tick(); reset = 0; #1;
      chk("rw_req", dmem_req, 0);
      chk("rw_stall", stall, 0);
      chk("rw_valid_w", valid_W, 0);
      chk("rw_err", mem_err, 0);
      dmem_ack = 1; dmem_rdata = 64'hBEEF; #1;
      chk("rw_late_req", dmem_req, 0);
      chk("rw_late_stall", stall, 0);
      tick(); dmem_ack = 0;
      chk("rw_late_valid_w", valid_W, 0);
      chk("rw_late_rdata", readData_W, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipelined memory stage of the 64-bit LEGv8 core, directly downstream of the execute stage.
- Contains the EX/MEM pipeline register. Consumes execute results: ALU result, store data, zero flag and branch target.
- Runs a valid/ack handshake to a data memory with variable latency, stalling upstream while an access is outstanding.
- Resolves CBZ/B branches and contains the MEM/WB register that feeds writeback.

Parameters:
N, 64, datapath width (address, ALU result, load/store data, PC)
TIMEOUT, 16, maximum cycles to wait for dmem_ack before aborting the access

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
valid_E  in  1  execute stage holds a real instruction
MemRead_E  in  1  load (LDUR)
MemWrite_E  in  1  store (STUR)
Branch_E  in  1  conditional branch on zero
RegWrite_E  in  1  writes register file
MemtoReg_E  in  1  writeback selects load data
WriteReg_E  in  5  destination register
PCBranch_E  in  N  branch target from execute
aluResult_E  in  N  ALU result / memory address
writeData_E  in  N  store data
zero_E  in  1  ALU zero flag
dmem_ack  in  1  memory completes the current request this cycle
dmem_rdata  in  N  load data, valid when dmem_ack=1
dmem_req  out  1  access request, held until ack or abort
dmem_we  out  1  1=write, 0=read
dmem_addr  out  N  address (aluResult_M)
dmem_wdata  out  N  store data (writeData_M)
stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
PCSrc_M  out  1  take branch
PCBranch_M  out  N  registered branch target
valid_W, RegWrite_W, MemtoReg_W  out  1 each  MEM/WB control
WriteReg_W  out  5  MEM/WB destination
aluResult_W, readData_W  out  N each  MEM/WB data
mem_err  out  1  sticky, set on timeout

Behaviour:
- Reset: every register cleared: valid_M=0, all _M/_W fields 0, state IDLE, wait counter 0, mem_err 0. Therefore dmem_req=0, stall=0, PCSrc_M=0 and all _W outputs 0. Reset mid-access drops the request in the same cycle; dmem_req is low after that edge.
- memop_M = valid_M & (MemRead_M | MemWrite_M). MemRead and MemWrite both set is illegal; the bench never drives it.
- EX/MEM register:
  - Loads all _E fields when stall=0.
  - valid_M <= valid_E & ~PCSrc_M, so the instruction behind a taken branch is squashed.
  - Holds when stall=1.
- Branch: PCSrc_M = valid_M & Branch_M & zero_M, combinational from the M registers. Branches are never memops, so PCSrc_M and stall never coincide.
- FSM:
  - IDLE: if memop_M, assert dmem_req. If dmem_ack in the same cycle, the access completes with zero extra cycles; otherwise go to WAIT with counter=1.
  - WAIT: dmem_req held. dmem_addr, dmem_wdata and dmem_we stay stable because the EX/MEM register is frozen.
    - On dmem_ack, complete and go to IDLE.
    - Else if counter==TIMEOUT-1, abort: mem_err<=1, go to IDLE.
    - Otherwise counter++.
- Combinational outputs:
  - dmem_req = memop_M & ~done_M, where done_M marks an access already completed or aborted for this M instruction.
  - dmem_we = MemWrite_M.
  - stall = dmem_req & ~dmem_ack & ~abort. The ack→stall path is combinational by design.
- MEM/WB register updates every cycle:
  - valid_W <= valid_M & ~stall & ~abort.
  - Control and aluResult copied from M.
  - readData_W <= dmem_rdata when the read is acked, else 0.
  - Aborted instruction: valid_W=0, no register write.
- Load latency: minimum 1 cycle M→W with immediate ack. With ack after k cycles, valid_W rises k cycles later; stall is high for exactly k cycles.
- mem_err clears only on reset.
- Ack while dmem_req=0 is ignored.

Decomposition:
- Shared package (core_pkg) holds:
  - typedef mem_state_t {IDLE, WAIT}.
  - Struct ex_mem_ctrl_t {valid, MemRead, MemWrite, Branch, RegWrite, MemtoReg, WriteReg}.
  - Struct mem_wb_ctrl_t {valid, RegWrite, MemtoReg, WriteReg}.
- One sub-module: dmem_handshake. It holds the FSM and wait counter; inputs memop/ack; outputs req, stall, done, abort, err.
- Pipeline registers stay in mem_stage using the existing enabled-flop pattern.

Test Plan:
- ALU op, valid_E=1, RegWrite_E=1, WriteReg_E=5, aluResult_E=0x2A, no memop -> one cycle later valid_W=1, WriteReg_W=5, aluResult_W=0x2A; stall never high.
- Load, addr 0x100, ack same cycle as dmem_req with rdata=0xDEAD -> dmem_req 1 cycle, stall 0, next cycle readData_W=0xDEAD, MemtoReg_W=1.
- Store, addr 0x80, data 0x55, ack delayed 3 cycles -> dmem_req and dmem_we high 4 cycles with addr/wdata stable, stall high 3 cycles, single valid_W pulse; the next E instruction is latched only after ack.
- CBZ with zero_E=1, PCBranch_E=0x400, followed by an ALU instruction -> PCSrc_M=1 and PCBranch_M=0x400 for one cycle; the following instruction never produces valid_W.
- Load with no ack, TIMEOUT=16 -> stall high 15 cycles then drops, dmem_req falls, valid_W=0 for that load, mem_err=1 and stays 1.
- Assert reset during the WAIT of a delayed load -> next cycle dmem_req=0, stall=0, valid_W=0, mem_err=0; a late ack afterwards is ignored.
